encoder_feeder: RTL and testbench
=================================

# encoder_feeder

Upstream framing stage for `encoder`. Accepts a continuous valid/ready message stream, buffers it in a small FIFO and drives `encoder`'s `gen_valid`/`gen_data`. After every `MSG_BEATS` valid beats it inserts exactly `PAR_BEATS` idle cycles so the encoder can emit parity. Back-pressure is applied to the source when needed.

## Interface
- `MSG_BEATS`, default 12: message length per codeword, in beats of `ENC_SYM` symbols.
- `PAR_BEATS`, default 4: idle cycles inserted after each message for parity output.
- `FIFO_DEPTH`, default 4: input buffer entries. Must be ≥2 and a power of two.
- Data width `W = ENC_SYM * EGF_DIM`, taken from the shared `encoder.vh` constants.
- Ports:
  - `clk`  in  1  single clock, rising edge.
  - `rst_n`  in  1  reset, asynchronous, active-low.
  - `src_valid`  in  1  source beat valid.
  - `src_data`  in  W  source beat; symbol order identical to `gen_data`.
  - `src_ready`  out  1  feeder can accept a beat this cycle.
  - `gen_valid`  out  1  to `encoder`: message beat valid.
  - `gen_data`  out  W  to `encoder`: message beat.
  - `frm_done`  out  1  one-cycle pulse on the last parity-gap cycle of each codeword.
  - `ovf_err`  out  1  sticky; set if `src_valid` is high while `src_ready` is low. Cleared only by reset.

## Operation
- Beat transfer: a source beat transfers on a rising edge when `src_valid && src_ready`.
- `src_ready = (fifo_count != FIFO_DEPTH)`, decoded from registered state only. There is no same-cycle pop credit.
- FIFO: circular buffer.
  - Pointers are `$clog2(FIFO_DEPTH)` bits with natural wrap-around.
  - `fifo_count` is `$clog2(FIFO_DEPTH)+1` bits.
  - A simultaneous push and pop leaves the count unchanged.
- FSM has two states, MSG (the reset state) and PAR.
- MSG state:
  - Each cycle the FIFO is non-empty: pop one entry, register it into `gen_data`, set `gen_valid=1`, increment `beat_cnt`.
  - When the FIFO is empty: `gen_valid=0`, `gen_data=0`, `beat_cnt` holds. Empty-FIFO gaps inside a message are legal; the encoder advances only on valid beats.
  - On the pop that makes `beat_cnt` reach `MSG_BEATS`: `beat_cnt` clears to 0 and the FSM goes to PAR.
- PAR state:
  - No pops. `gen_valid=0`, `gen_data=0`.
  - `par_cnt` counts 0 to `PAR_BEATS-1`.
  - On `par_cnt==PAR_BEATS-1`: `frm_done=1`, `par_cnt` clears, FSM returns to MSG.
  - The FIFO keeps accepting beats until full.
- Counters: `beat_cnt` is `$clog2(MSG_BEATS+1)` bits; `par_cnt` is `$clog2(PAR_BEATS+1)` bits.
- Overflow: a push while full is dropped and sets `ovf_err`. FIFO contents are unaffected.

## Timing
- All outputs are registered except `src_ready`, which is a registered-state decode.
- Reset values: `src_ready=1`, `gen_valid=0`, `gen_data=0`, `frm_done=0`, `ovf_err=0`. The FSM is in MSG, all counters are 0, the FIFO is empty.
- Latency: a beat accepted at edge k appears on `gen_valid`/`gen_data` after edge k+1 at the earliest.
- Throughput: sustains one beat per cycle in MSG when the source never stalls.
- Codeword period with a non-stalling source: exactly `MSG_BEATS + PAR_BEATS` cycles, i.e. 16 with defaults.
- `frm_done` is high in the same cycle as the final idle `gen_valid=0` of the gap.
- Reset mid-operation:
  - The partial message and FIFO contents are discarded.
  - `gen_valid` drops asynchronously.
  - The next accepted beat starts a new codeword at `beat_cnt=0`.
  - `encoder` shares `rst_n`, so both stages realign.
- `MSG_BEATS=1` is legal: every popped beat is followed by PAR.

## Structure
- `W`, `ENC_SYM` and `EGF_DIM` come from the shared `encoder.vh` package.
- Add to that package:
  - the FSM state typedef (`feed_state_t`: `FEED_MSG`, `FEED_PAR`);
  - default constants `ENC_MSG_BEATS` and `ENC_PAR_BEATS`, so `encoder` and the feeder agree on codeword geometry.
- One sub-module, `feeder_fifo`: a parameterised sync FIFO with push, pop, `count`, `full`, `empty`. The FSM and counters live in `encoder_feeder`.
- Integration: instantiate above `encoder`, connecting `gen_valid`/`gen_data` directly.

## Test plan
Configuration for all scenarios: `W=16`, `MSG_BEATS=12`, `PAR_BEATS=4`, `FIFO_DEPTH=4`.
1. **Reset:** assert `rst_n=0` mid-cycle → all outputs reach reset values immediately, without waiting for a clock edge. `src_ready=1` after release.
2. **Streaming:** stream 0x0123, 0x4567, 0x89ab, 0xcdef repeated ×6 with `src_valid` held high → `gen_valid` high for 12 consecutive cycles with the same order, then low for 4 cycles. `frm_done` pulses on the 4th idle cycle, then the second codeword follows. Zero data loss. `src_ready` drops only during PAR once the FIFO is full.
3. **Source stalls:** source pauses 3 cycles after beat 5 → `gen_valid` has a 3-cycle gap, the PAR gap still starts only after the 12th valid beat, and `beat_cnt` is preserved across the gap.
4. **Overflow:** hold `src_valid=1` while ignoring `src_ready` during PAR → `ovf_err=1` and stays 1. The FIFO delivers only the 4 accepted beats.
5. **Reset mid-frame:** reset after 7 message beats → no stale beats are emitted after release, and the next 12 accepted beats form a complete codeword followed by a 4-cycle gap.
6. **Wrap and simultaneous push/pop:** run 100 codewords of random data with a random source `src_valid` pattern → output sequence equals input sequence. Every codeword has exactly 12 valid beats, and every gap is exactly 4 idle cycles with no message beats.

Source files
------------

// File: rtl/encoder_feeder_pkg.sv
// encoder_feeder_pkg: shared codeword geometry, data width and feeder FSM state type
package encoder_feeder_pkg;
  localparam int ENC_SYM = 2;
  localparam int EGF_DIM = 8;
  localparam int W = ENC_SYM * EGF_DIM;
  localparam int ENC_MSG_BEATS = 12;
  localparam int ENC_PAR_BEATS = 4;
  typedef enum logic {FEED_MSG, FEED_PAR} feed_state_t;
endpackage

// File: rtl/encoder_feeder_fifo.sv
// feeder_fifo: circular sync FIFO; ports clk, rst_n, push/din, pop/dout (show-ahead), count, full, empty
module feeder_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/encoder_feeder.sv
// encoder_feeder: buffers src_valid/src_data/src_ready stream into gen_valid/gen_data with PAR_BEATS idle gap per message; frm_done, ovf_err
module encoder_feeder
  import encoder_feeder_pkg::*;
#(
  parameter int MSG_BEATS = ENC_MSG_BEATS,
  parameter int PAR_BEATS = ENC_PAR_BEATS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  output logic         src_ready,
  output logic         gen_valid,
  output logic [W-1:0] gen_data,
  output logic         frm_done,
  output logic         ovf_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(MSG_BEATS + 1);
  localparam int PW = $clog2(PAR_BEATS + 1);
  feed_state_t state;
  logic [BW-1:0] beat_cnt;
  logic [PW-1:0] par_cnt;
  logic [CW-1:0] fifo_count;
  logic [W-1:0] fifo_dout;
  logic fifo_full, fifo_empty, pop;
  assign src_ready = fifo_count != CW'(FIFO_DEPTH);
  assign pop = state == FEED_MSG && !fifo_empty;
  feeder_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(src_valid && !fifo_full),
    .din(src_data),
    .pop(pop),
    .dout(fifo_dout),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FEED_MSG;
      beat_cnt <= '0;
      par_cnt <= '0;
      gen_valid <= 1'b0;
      gen_data <= '0;
      frm_done <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_err || (src_valid && !src_ready);
      gen_valid <= pop;
      gen_data <= pop ? fifo_dout : '0;
      frm_done <= 1'b0;
      if (state == FEED_MSG) begin
        if (pop) begin
          beat_cnt <= beat_cnt == BW'(MSG_BEATS - 1) ? '0 : beat_cnt + 1'b1;
          if (beat_cnt == BW'(MSG_BEATS - 1)) state <= FEED_PAR;
        end
      end else begin
        par_cnt <= par_cnt == PW'(PAR_BEATS - 1) ? '0 : par_cnt + 1'b1;
        if (par_cnt == PW'(PAR_BEATS - 1)) begin
          frm_done <= 1'b1;
          state <= FEED_MSG;
        end
      end
    end
endmodule

// File: tb/tb_encoder_feeder.sv
// tb_encoder_feeder: random and directed stimulus checked against a queue-based framing model
module tb_encoder_feeder;
  localparam int DW = 16;
  localparam int MB = 12;
  localparam int PB = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic src_ready, gen_valid, frm_done, ovf_err;
  logic [DW-1:0] gen_data;
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] q[$];
  int gap_left = 0;
  int beats = 0;
  bit m_ready = 1'b1;
  bit m_ovf = 1'b0;
  logic [DW-1:0] pat [4] = '{16'h0123, 16'h4567, 16'h89ab, 16'hcdef};
  always #5 clk = ~clk;
  encoder_feeder #(.MSG_BEATS(MB), .PAR_BEATS(PB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .gen_valid(gen_valid),
    .gen_data(gen_data),
    .frm_done(frm_done),
    .ovf_err(ovf_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask
  task automatic check_outputs(input bit e_valid, input logic [DW-1:0] e_data, input bit e_done);
    check("gen_valid", 32'(gen_valid), 32'(e_valid));
    check("gen_data", 32'(gen_data), 32'(e_data));
    check("frm_done", 32'(frm_done), 32'(e_done));
    check("ovf_err", 32'(ovf_err), 32'(m_ovf));
    check("src_ready", 32'(src_ready), 32'(m_ready));
  endtask
  task automatic cycle(input logic v, input logic [DW-1:0] d, output bit acc);
    bit e_valid, e_done;
    logic [DW-1:0] e_data;
    src_valid = v;
    src_data = d;
    @(posedge clk);
    acc = v && m_ready;
    m_ovf = m_ovf || (v && !m_ready);
    e_valid = 1'b0;
    e_done = 1'b0;
    e_data = '0;
    if (gap_left > 0) begin
      e_done = gap_left == 1;
      gap_left--;
    end else if (q.size() > 0) begin
      e_valid = 1'b1;
      e_data = q.pop_front();
      beats++;
      if (beats == MB) begin
        beats = 0;
        gap_left = PB;
      end
    end
    if (acc) q.push_back(d);
    m_ready = q.size() != DEPTH;
    #1;
    check_outputs(e_valid, e_data, e_done);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, acc);
  endtask
  task automatic send(input int n, input int pct, input bit ignore_ready, input bit use_pat);
    int sent = 0;
    int guard = 0;
    bit acc;
    logic v;
    logic [DW-1:0] d;
    while (sent < n && guard < 20000) begin
      v = $urandom_range(99) < pct;
      if (!ignore_ready && !m_ready) v = 1'b0;
      d = use_pat ? pat[sent % 4] : DW'($urandom);
      cycle(v, d, acc);
      if (acc) sent++;
      guard++;
    end
    check("send_budget", 32'(sent), 32'(n));
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    gap_left = 0;
    beats = 0;
    m_ready = 1'b1;
    m_ovf = 1'b0;
    check_outputs(1'b0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_reset", 32'(src_ready), 32'(1));
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    idle(2);
    send(48, 100, 1'b0, 1'b1);
    idle(20);
    send(5, 100, 1'b0, 1'b1);
    idle(3);
    send(7, 100, 1'b0, 1'b1);
    idle(20);
    send(14, 100, 1'b0, 1'b0);
    send(16, 100, 1'b1, 1'b0);
    idle(20);
    check("ovf_sticky", 32'(ovf_err), 32'(1));
    send(7, 100, 1'b0, 1'b0);
    idle(3);
    do_reset();
    send(12, 100, 1'b0, 1'b0);
    idle(20);
    send(MB * 100, 70, 1'b0, 1'b0);
    idle(30);
    check("fifo_drained", 32'(q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
